// File: rtl/reg_ctrl_pkg.sv
// rtl/reg_ctrl_pkg.sv - shared constants and types for the register-file write path
package reg_ctrl_pkg;

    localparam int pw       = 4;
    localparam int NREQ     = 3;
    localparam int CW       = 16;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IMM  = 2;

    typedef struct packed {
        logic [pw-1:0] addr;
        logic [7:0]    data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    int   cand;
    int   sel;
    logic hit;

    // Scan ptr+1, ptr+2, ... wrapping, so the previous winner is checked last.
    always_comb begin
        grant = '0;
        hit   = 1'b0;
        sel   = 0;
        cand  = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(ptr) + off) % NREQ;
            if (!hit && ((req >> cand) & NREQ'(1)) != '0) begin
                hit = 1'b1;
                sel = cand;
            end
        end
        if (hit && en) begin
            grant = NREQ'(1) << sel;
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// rtl/reg_wr_arbiter.sv - round-robin sharing of the register-file write port
module reg_wr_arbiter #(
    parameter int pw   = 4,
    parameter int NREQ = 3,
    parameter int CW   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0][pw-1:0]        req_addr,
    input  logic [NREQ-1:0][7:0]           req_data,
    input  logic                           hold,
    output logic                           wr_en,
    output logic [pw-1:0]                  wr_addr,
    output logic [7:0]                     dat_in,
    output logic [(NREQ>1 ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic [(2**pw)-1:0]             busy,
    output logic [CW-1:0]                  wr_count
);

    import reg_ctrl_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic            sv;
    wr_req_t         stage_q;
    logic [IW-1:0]   id_q;
    logic [IW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;

    logic            load_ok;
    logic            accept;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   win_idx;
    wr_req_t         win_req;

    // Reset masks both the write and any new accept in the same cycle.
    assign wr_en   = sv & ~hold & ~reset;
    assign load_ok = (~sv | ~hold) & ~reset;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (load_ok),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        win_idx = '0;
        win_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx      = IW'(i);
                win_req.addr = req_addr[i];
                win_req.data = req_data[i];
            end
        end
    end

    // A drain and a new accept in the same cycle simply overwrite the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sv      <= 1'b0;
            stage_q <= '0;
            id_q    <= '0;
            ptr_q   <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            if (wr_en) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (accept) begin
                sv      <= 1'b1;
                stage_q <= win_req;
                id_q    <= win_idx;
                ptr_q   <= win_idx;
            end else if (wr_en) begin
                sv <= 1'b0;
            end
        end
    end

    always_comb begin
        busy = '0;
        if (sv) begin
            busy[stage_q.addr] = 1'b1;
        end
    end

    assign wr_addr  = stage_q.addr;
    assign dat_in   = stage_q.data;
    assign grant_id = id_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb/tb_reg_wr_arbiter.sv - directed bench with a per-cycle behavioural model of the write port
module tb_reg_wr_arbiter;

    import reg_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            hold = 1'b0;
    logic [2:0]      req_valid = '0;
    logic [2:0]      req_ready;
    logic [2:0][3:0] req_addr = '0;
    logic [2:0][7:0] req_data = '0;
    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [7:0]      dat_in;
    logic [1:0]      grant_id;
    logic [15:0]     busy;
    logic [15:0]     wr_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    bit         m_sv;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    int         m_id;
    int         m_ptr;
    int         m_cnt;
    logic [7:0] m_rf [16];

    reg_wr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .hold      (hold),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .dat_in    (dat_in),
        .grant_id  (grant_id),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: stage = at most one pending write; arbitration from the rules in plain arithmetic.
    initial begin
        int  win;
        bit  we;
        bit  lok;
        bit  rst;
        logic [3:0] in_addr [3];
        logic [7:0] in_data [3];
        m_sv = 0; m_addr = 0; m_data = 0; m_id = 0; m_ptr = 2; m_cnt = 0;
        for (int r = 0; r < 16; r++) m_rf[r] = 8'h00;
        forever begin
            @(negedge clk);
            rst = reset;
            we  = m_sv && !hold && !rst;
            lok = (!m_sv || !hold) && !rst;
            win = -1;
            if (lok) begin
                for (int k = 1; k <= 3; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
                end
            end
            for (int r = 0; r < 3; r++) begin
                in_addr[r] = req_addr[r];
                in_data[r] = req_data[r];
            end
            if (chk_on) begin
                chk("req_ready", {29'd0, req_ready}, (win >= 0) ? (32'd1 << win) : 32'd0);
                chk("wr_en", {31'd0, wr_en}, {31'd0, we});
                chk("busy", {16'd0, busy}, m_sv ? (32'd1 << m_addr) : 32'd0);
                chk("wr_count", {16'd0, wr_count}, m_cnt);
                if (m_sv) begin
                    chk("wr_addr", {28'd0, wr_addr}, {28'd0, m_addr});
                    chk("dat_in", {24'd0, dat_in}, {24'd0, m_data});
                    chk("grant_id", {30'd0, grant_id}, m_id);
                end
            end
            @(posedge clk);
            if (rst) begin
                m_sv = 0; m_addr = 0; m_data = 0; m_id = 0; m_ptr = 2; m_cnt = 0;
            end else begin
                if (we) begin
                    m_rf[m_addr] = m_data;
                    m_cnt = (m_cnt + 1) % 65536;
                end
                if (win >= 0) begin
                    m_sv = 1; m_addr = in_addr[win]; m_data = in_data[win];
                    m_id = win; m_ptr = win;
                end else if (we) begin
                    m_sv = 0;
                end
            end
        end
    end

    initial begin
        bit hit;
        reset = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_dat_in", {24'd0, dat_in}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_busy", {16'd0, busy}, 32'd0);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        step();

        // single write from the ALU port
        req_valid = 3'b001; req_addr[REQ_ALU] = 4'd3; req_data[REQ_ALU] = 8'hA5;
        @(negedge clk);
        chk("t1_ready", {29'd0, req_ready}, 32'b001);
        step();
        req_valid = 3'b000;
        @(negedge clk);
        chk("t1_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t1_wr_addr", {28'd0, wr_addr}, 32'd3);
        chk("t1_dat_in", {24'd0, dat_in}, 32'hA5);
        chk("t1_busy", {16'd0, busy}, 32'h0008);
        chk("t1_grant_id", {30'd0, grant_id}, 32'd0);
        step();
        @(negedge clk);
        chk("t1_wr_en_off", {31'd0, wr_en}, 32'd0);
        chk("t1_busy_off", {16'd0, busy}, 32'd0);
        chk("t1_count", {16'd0, wr_count}, 32'd1);
        step();

        // rotation with all three requesters valid
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 3'b111;
        req_addr[0] = 4'd1; req_data[0] = 8'h10;
        req_addr[1] = 4'd2; req_data[1] = 8'h20;
        req_addr[2] = 4'd4; req_data[2] = 8'h30;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_ready", {29'd0, req_ready}, 32'd1 << (i % 3));
            if (i > 0) chk("t2_wr_en", {31'd0, wr_en}, 32'd1);
            step();
        end
        req_valid = 3'b000;
        @(negedge clk);
        chk("t2_last_wr_en", {31'd0, wr_en}, 32'd1);
        step();
        @(negedge clk);
        chk("t2_count", {16'd0, wr_count}, 32'd6);
        step();

        // hold while the stage is full
        req_valid = 3'b001; req_addr[0] = 4'd5; req_data[0] = 8'h11;
        @(negedge clk);
        chk("t3_accept", {29'd0, req_ready}, 32'b001);
        step();
        hold = 1'b1;
        req_valid = 3'b010; req_addr[1] = 4'd6; req_data[1] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_wr_en", {31'd0, wr_en}, 32'd0);
            chk("t3_hold_ready", {29'd0, req_ready}, 32'd0);
            chk("t3_hold_addr", {28'd0, wr_addr}, 32'd5);
            chk("t3_hold_data", {24'd0, dat_in}, 32'h11);
            chk("t3_hold_busy", {16'd0, busy}, 32'h0020);
            step();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("t3_rel_wr_en", {31'd0, wr_en}, 32'd1);
        chk("t3_rel_addr", {28'd0, wr_addr}, 32'd5);
        chk("t3_rel_data", {24'd0, dat_in}, 32'h11);
        chk("t3_rel_ready", {29'd0, req_ready}, 32'b010);
        step();
        req_valid = 3'b000;
        @(negedge clk);
        chk("t3_next_addr", {28'd0, wr_addr}, 32'd6);
        chk("t3_next_data", {24'd0, dat_in}, 32'h22);
        step();
        @(negedge clk);
        chk("t3_rf5", {24'd0, m_rf[5]}, 32'h11);
        chk("t3_rf6", {24'd0, m_rf[6]}, 32'h22);
        step();

        // same destination from two requesters: later accept wins
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 3'b101;
        req_addr[0] = 4'd7; req_data[0] = 8'h01;
        req_addr[2] = 4'd7; req_data[2] = 8'h02;
        @(negedge clk);
        chk("t4_ready0", {29'd0, req_ready}, 32'b001);
        step();
        req_valid = 3'b100;
        @(negedge clk);
        chk("t4_ready2", {29'd0, req_ready}, 32'b100);
        chk("t4_gid0", {30'd0, grant_id}, 32'd0);
        step();
        req_valid = 3'b000;
        @(negedge clk);
        chk("t4_gid2", {30'd0, grant_id}, 32'd2);
        chk("t4_data", {24'd0, dat_in}, 32'h02);
        step();
        @(negedge clk);
        chk("t4_rf7", {24'd0, m_rf[7]}, 32'h02);
        chk("t4_idle", {31'd0, wr_en}, 32'd0);
        step();

        // reset discards a pending entry
        req_valid = 3'b001; req_addr[0] = 4'd9; req_data[0] = 8'hFF;
        @(negedge clk);
        chk("t5_accept", {29'd0, req_ready}, 32'b001);
        step();
        req_valid = 3'b000;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_wr_en", {31'd0, wr_en}, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_wr_en", {31'd0, wr_en}, 32'd0);
        chk("t5_busy", {16'd0, busy}, 32'd0);
        chk("t5_count", {16'd0, wr_count}, 32'd0);
        chk("t5_rf9", {24'd0, m_rf[9]}, 32'h00);
        step();

        // counter wrap after 65536 commits
        req_valid = 3'b111;
        hit = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            if (m_cnt == 65535) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("t6_reached", {31'd0, hit}, 32'd1);
        req_valid = 3'b000;
        @(negedge clk);
        chk("t6_pre_count", {16'd0, wr_count}, 32'hFFFF);
        chk("t6_pre_wr_en", {31'd0, wr_en}, 32'd1);
        step();
        @(negedge clk);
        chk("t6_wrap", {16'd0, wr_count}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
